latch_load_ctrl: RTL and testbench

Upstream load sequencer for a level-sensitive transparent latch whose enable is active-low (latch passes `d` while its enable is 0 and holds while it is 1). Accepts data words over a valid/ready handshake. For each word it drives the latch data, opens the latch for a programmed number of cycles and then closes it. It also holds the data stable for a programmed hold window so the latch never closes on a changing input. Sits between a synchronous producer and the latch's `clk`/`d` inputs.

---
 rtl/latch_load_ctrl_if.sv | 24 ++
 rtl/latch_load_ctrl.sv | 110 +++++++++++
 tb/tb_latch_load_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/latch_load_ctrl_if.sv
// Producer handshake and latch-drive bundle for latch_load_ctrl.
// slave is the controller side; master is the producer/latch side.
interface latch_load_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             lat_en_n;
  logic [WIDTH-1:0] lat_d;
  logic             busy;
  logic             done;
  logic [7:0]       load_count;

  modport master (
    output in_valid, in_data,
    input  in_ready, lat_en_n, lat_d, busy, done, load_count
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, lat_en_n, lat_d, busy, done, load_count
  );
endinterface

// File: rtl/latch_load_ctrl.sv
// Load sequencer for an active-low-enable transparent latch: accept a word,
// settle it, open the latch for OPEN_CYCLES, then hold data for HOLD_CYCLES.
module latch_load_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned OPEN_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input logic              clk,
  input logic              reset,
  latch_load_ctrl_if.slave bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LCNT_W = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_OPEN  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [CNT_W-1:0] OPEN_LOAD = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [1:0]        state_q,      state_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic [WIDTH-1:0]  lat_d_q,      lat_d_d;
  logic              lat_en_n_q,   lat_en_n_d;
  logic              in_ready_q,   in_ready_d;
  logic              done_q,       done_d;
  logic [LCNT_W-1:0] load_count_q, load_count_d;

  // lat_d moves only on accept and lat_en_n only on SETUP->OPEN / OPEN->HOLD,
  // so the two never change on the same edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_d_d      = lat_d_q;
    lat_en_n_d   = lat_en_n_q;
    in_ready_d   = in_ready_q;
    done_d       = 1'b0;
    load_count_d = load_count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          lat_d_d    = bus.in_data;
          in_ready_d = 1'b0;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        lat_en_n_d = 1'b0;
        cnt_d      = OPEN_LOAD;
        state_d    = S_OPEN;
      end
      S_OPEN: begin
        if (cnt_q == CNT_W'(0)) begin
          lat_en_n_d = 1'b1;
          cnt_d      = HOLD_LOAD;
          state_d    = S_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_W'(0)) begin
          in_ready_d   = 1'b1;
          done_d       = 1'b1;
          load_count_d = load_count_q + LCNT_W'(1);
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        lat_en_n_d = 1'b1;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // Reset closes the latch at once and drops any in-flight word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lat_d_q      <= '0;
      lat_en_n_q   <= 1'b1;
      in_ready_q   <= 1'b1;
      done_q       <= 1'b0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_d_q      <= lat_d_d;
      lat_en_n_q   <= lat_en_n_d;
      in_ready_q   <= in_ready_d;
      done_q       <= done_d;
      load_count_q <= load_count_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.lat_en_n   = lat_en_n_q;
  assign bus.lat_d      = lat_d_q;
  assign bus.done       = done_q;
  assign bus.load_count = load_count_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_latch_load_ctrl.sv
// Directed bench for latch_load_ctrl with a behavioural active-low latch
// attached; a second instance runs OPEN_CYCLES=1, HOLD_CYCLES=3 to wrap the counter.
module tb_latch_load_ctrl;
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic reset;

  latch_load_ctrl_if #(.WIDTH(WIDTH)) bus  ();
  latch_load_ctrl_if #(.WIDTH(WIDTH)) bus2 ();

  latch_load_ctrl #(.WIDTH(WIDTH), .OPEN_CYCLES(2), .HOLD_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  latch_load_ctrl #(.WIDTH(WIDTH), .OPEN_CYCLES(1), .HOLD_CYCLES(3)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] latch_q;
  always_latch begin
    if (!bus.lat_en_n) latch_q <= bus.lat_d;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin : stim
    logic [WIDTH-1:0] words [3];
    int done_seen;
    int last_done;
    int bad_gap;
    int first_done;
    int busy_ready;

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus2.in_valid = 1'b0;
    bus2.in_data  = 8'h3C;

    // Reset asserted mid-cycle, checked before any clock edge
    #2 reset = 1'b1;
    #1;
    chk("rst_lat_en_n",   32'(bus.lat_en_n),   32'd1);
    chk("rst_lat_d",      32'(bus.lat_d),      32'h00);
    chk("rst_in_ready",   32'(bus.in_ready),   32'd1);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    chk("rst_done",       32'(bus.done),       32'd0);
    chk("rst_load_count", 32'(bus.load_count), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Single load of A5 with default timing
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    tick();
    chk("s_lat_d_e0",    32'(bus.lat_d),    32'hA5);
    chk("s_in_ready_e0", 32'(bus.in_ready), 32'd0);
    chk("s_busy_e0",     32'(bus.busy),     32'd1);
    chk("s_en_n_e0",     32'(bus.lat_en_n), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("s_en_n_e1", 32'(bus.lat_en_n), 32'd0);
    tick();
    chk("s_en_n_e2", 32'(bus.lat_en_n), 32'd0);
    tick();
    chk("s_en_n_e3", 32'(bus.lat_en_n), 32'd1);
    chk("s_done_e3", 32'(bus.done),     32'd0);
    chk("s_lat_d_e3", 32'(bus.lat_d),   32'hA5);
    tick();
    chk("s_done_e4",     32'(bus.done),       32'd1);
    chk("s_in_ready_e4", 32'(bus.in_ready),   32'd1);
    chk("s_busy_e4",     32'(bus.busy),       32'd0);
    chk("s_count_e4",    32'(bus.load_count), 32'd1);
    chk("s_latch_q_b0",  32'(latch_q[0]),     32'd1);
    chk("s_latch_q",     32'(latch_q),        32'hA5);
    tick();
    chk("s_done_e5", 32'(bus.done), 32'd0);

    // Loads of 01 then 00 while in_data toggles during busy
    for (int w = 0; w < 2; w++) begin
      logic [WIDTH-1:0] word;
      word = (w == 0) ? 8'h01 : 8'h00;
      bus.in_valid = 1'b1;
      bus.in_data  = word;
      tick();
      chk("h_lat_d_acc", 32'(bus.lat_d), 32'(word));
      bus.in_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        bus.in_data = ~bus.in_data;
        tick();
        chk("h_lat_d_busy", 32'(bus.lat_d), 32'(word));
        if (c == 4) begin
          chk("h_done",    32'(bus.done), 32'd1);
          chk("h_latch_q", 32'(latch_q),  32'(word));
        end
      end
    end
    chk("h_count", 32'(bus.load_count), 32'd3);

    // Back-to-back: in_valid held high for 11/22/33
    do_reset();
    words[0] = 8'h11;
    words[1] = 8'h22;
    words[2] = 8'h33;
    done_seen  = 0;
    busy_ready = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = words[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_lat_d_acc", 32'(bus.lat_d),    32'(words[i]));
      chk("b_ready_acc", 32'(bus.in_ready), 32'd0);
      if (i < 2) bus.in_data = words[i+1];
      else       bus.in_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        tick();
        if (bus.done) done_seen++;
        if (bus.in_ready && bus.busy) busy_ready++;
      end
      chk("b_done_slot", 32'(bus.done), 32'd1);
    end
    tick();
    chk("b_no_extra_accept", 32'(bus.busy),       32'd0);
    chk("b_done_count",      32'(done_seen),      32'd3);
    chk("b_load_count",      32'(bus.load_count), 32'd3);
    chk("b_ready_while_busy", 32'(busy_ready),    32'd0);
    chk("b_latch_q",         32'(latch_q),        32'h33);

    // Reset while the latch is open
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("r_en_n_open", 32'(bus.lat_en_n), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("r_en_n_now",  32'(bus.lat_en_n),   32'd1);
    chk("r_lat_d_now", 32'(bus.lat_d),      32'h00);
    chk("r_count_now", 32'(bus.load_count), 32'd0);
    chk("r_done_now",  32'(bus.done),       32'd0);
    chk("r_busy_now",  32'(bus.busy),       32'd0);
    tick();
    reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.done) done_seen++;
    end
    chk("r_no_done",    32'(done_seen),      32'd0);
    chk("r_count_idle", 32'(bus.load_count), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h0F;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    chk("r_done_new",  32'(bus.done),       32'd1);
    chk("r_count_new", 32'(bus.load_count), 32'd1);
    chk("r_latch_q",   32'(latch_q),        32'h0F);

    // 256 back-to-back loads on the OPEN=1 / HOLD=3 instance
    do_reset();
    done_seen  = 0;
    last_done  = 0;
    bad_gap    = 0;
    first_done = -1;
    busy_ready = 0;
    bus2.in_valid = 1'b1;
    tick();
    chk("w_accept", 32'(bus2.busy), 32'd1);
    for (int n = 1; n <= 256 * 6 + 20 && done_seen < 256; n++) begin
      tick();
      if (n == 1) chk("w_en_n_e1", 32'(bus2.lat_en_n), 32'd0);
      if (n == 2) chk("w_en_n_e2", 32'(bus2.lat_en_n), 32'd1);
      if (bus2.in_ready && bus2.busy) busy_ready++;
      if (bus2.done) begin
        done_seen++;
        if (first_done < 0) first_done = n;
        else if (n - last_done != 6) bad_gap++;
        last_done = n;
        if (done_seen == 255) chk("w_count_255", 32'(bus2.load_count), 32'd255);
        if (done_seen == 256) bus2.in_valid = 1'b0;
      end
    end
    chk("w_done_total", 32'(done_seen),        32'd256);
    chk("w_first_done", 32'(first_done),       32'd5);
    chk("w_bad_gaps",   32'(bad_gap),          32'd0);
    chk("w_count_wrap", 32'(bus2.load_count),  32'd0);
    chk("w_ready_busy", 32'(busy_ready),       32'd0);
    tick();
    chk("w_idle_after", 32'(bus2.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
